// File: rtl/mem_resp_demux_pkg.sv
// ============================================================================
// Module : mem_resp_pkg
// Brief  : Shared constants and helpers for the memory response demux.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mem_resp_pkg;

  localparam logic SEL_IF  = 1'b0;
  localparam logic SEL_MEM = 1'b1;

  // Ceiling log2; returns 1 for values <= 2 so pointers are never zero-width.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_resp_demux_tag_fifo.sv
// ============================================================================
// Module : tag_fifo
// Brief  : 1-bit-wide in-order tag FIFO recording the owner of each request.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tag_fifo
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          tag_i,
  output logic          head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [DEPTH-1:0] tags_q;
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  // The caller guarantees no push while full without a pop, and no pop while empty.
  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + CW'(1);
    end else if (pop_i && !push_i) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tags_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        tags_q[wptr_q] <= tag_i;
        wptr_q         <= wptr_q + PW'(1);
      end
      if (pop_i) begin
        rptr_q <= rptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  assign head_o  = tags_q[rptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/mem_resp_demux.sv
// ============================================================================
// Module : mem_resp_demux
// Brief  : Steers shared-port memory responses back to IF or MEM in request
//          order, with flush-drop and error flags. MEM_RESP_BYPASS_EN selects
//          0-cycle combinational routing instead of registered outputs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_resp_demux
  import mem_resp_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_fire,
  input  logic         req_sel,
  input  logic         flush,
  input  logic         resp_valid,
  input  logic [N-1:0] resp_data,
  output logic         if_valid,
  output logic [N-1:0] if_data,
  output logic         mem_valid,
  output logic [N-1:0] mem_data,
  output logic         full,
  output logic         empty,
  output logic         ovf,
  output logic         orphan
);

  localparam int CW = clog2(DEPTH) + 1;

  logic          w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic          w_pop;
  logic          w_push;
  logic          w_route;
  logic          w_orphan;

  logic [CW-1:0] drop_q;
  logic [CW-1:0] drop_d;
  logic          ovf_q;
  logic          ovf_d;

  assign w_pop    = resp_valid & ~w_empty;
  assign w_push   = req_fire & (~w_full | w_pop);
  assign w_route  = w_pop & (drop_q == '0);
  assign w_orphan = resp_valid & w_empty & (drop_q == '0);

  tag_fifo #(
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .tag_i   (req_sel),
    .head_o  (w_head),
    .count_o (w_count),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Flush marks every entry surviving this edge as stale; a push in the same
  // cycle is a fresh post-flush request and is not counted.
  always_comb begin
    drop_d = drop_q;
    if (flush) begin
      drop_d = w_count - CW'(w_pop);
    end else if (w_pop && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end
  end

  assign ovf_d = ovf_q | (req_fire & w_full & ~w_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
    end
  end

`ifdef MEM_RESP_BYPASS_EN
  assign if_valid  = w_route & (w_head == SEL_IF);
  assign mem_valid = w_route & (w_head == SEL_MEM);
  assign if_data   = resp_data;
  assign mem_data  = resp_data;
  assign orphan    = w_orphan;
`else
  logic         if_valid_q;
  logic         mem_valid_q;
  logic [N-1:0] if_data_q;
  logic [N-1:0] mem_data_q;
  logic         orphan_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      if_data_q   <= '0;
      mem_data_q  <= '0;
      orphan_q    <= 1'b0;
    end else begin
      if_valid_q  <= w_route & (w_head == SEL_IF);
      mem_valid_q <= w_route & (w_head == SEL_MEM);
      orphan_q    <= w_orphan;
      if (w_route && (w_head == SEL_IF)) begin
        if_data_q <= resp_data;
      end
      if (w_route && (w_head == SEL_MEM)) begin
        mem_data_q <= resp_data;
      end
    end
  end

  assign if_valid  = if_valid_q;
  assign mem_valid = mem_valid_q;
  assign if_data   = if_data_q;
  assign mem_data  = mem_data_q;
  assign orphan    = orphan_q;
`endif

  assign full  = w_full;
  assign empty = w_empty;
  assign ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_resp_demux.sv
// ============================================================================
// Module : tb_mem_resp_demux
// Brief  : Self-checking bench for mem_resp_demux against a queue-based model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_resp_demux;

  localparam int N     = 32;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_fire = 1'b0;
  logic         req_sel = 1'b0;
  logic         flush = 1'b0;
  logic         resp_valid = 1'b0;
  logic [N-1:0] resp_data = '0;
  logic         if_valid;
  logic [N-1:0] if_data;
  logic         mem_valid;
  logic [N-1:0] mem_data;
  logic         full;
  logic         empty;
  logic         ovf;
  logic         orphan;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mem_resp_demux #(.N(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_fire   (req_fire),
    .req_sel    (req_sel),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .if_valid   (if_valid),
    .if_data    (if_data),
    .mem_valid  (mem_valid),
    .mem_data   (mem_data),
    .full       (full),
    .empty      (empty),
    .ovf        (ovf),
    .orphan     (orphan)
  );

  // Reference model: outstanding owners in a queue, stale responses as a count.
  bit           q[$];
  int           m_drop = 0;
  bit           m_ovf = 1'b0;
  bit           m_if_v = 1'b0;
  bit           m_mem_v = 1'b0;
  bit           m_orphan = 1'b0;
  logic [N-1:0] m_if_d = '0;
  logic [N-1:0] m_mem_d = '0;

  always @(posedge clk) begin
    bit tag;
    m_if_v   = 1'b0;
    m_mem_v  = 1'b0;
    m_orphan = 1'b0;
    if (!rst) begin
      q.delete();
      m_drop  = 0;
      m_ovf   = 1'b0;
      m_if_d  = '0;
      m_mem_d = '0;
    end else begin
      if (resp_valid && q.size() > 0) begin
        tag = q.pop_front();
        if (m_drop > 0) begin
          m_drop = m_drop - 1;
        end else if (tag) begin
          m_mem_v = 1'b1;
          m_mem_d = resp_data;
        end else begin
          m_if_v = 1'b1;
          m_if_d = resp_data;
        end
      end else if (resp_valid && m_drop == 0) begin
        m_orphan = 1'b1;
      end
      if (flush) m_drop = q.size();
      if (req_fire) begin
        if (q.size() < DEPTH) q.push_back(req_sel);
        else m_ovf = 1'b1;
      end
    end
  end

  task automatic cmp(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("if_valid",  N'(if_valid),  N'(m_if_v));
      cmp("mem_valid", N'(mem_valid), N'(m_mem_v));
      cmp("if_data",   if_data,       m_if_d);
      cmp("mem_data",  mem_data,      m_mem_d);
      cmp("full",      N'(full),      N'(q.size() == DEPTH));
      cmp("empty",     N'(empty),     N'(q.size() == 0));
      cmp("ovf",       N'(ovf),       N'(m_ovf));
      cmp("orphan",    N'(orphan),    N'(m_orphan));
    end
  end

  task automatic drive(input bit r, input bit rf, input bit sel, input bit fl,
                       input bit rv, input logic [N-1:0] d);
    @(negedge clk);
    rst        = r;
    req_fire   = rf;
    req_sel    = sel;
    flush      = fl;
    resp_valid = rv;
    resp_data  = d;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk_en = 1'b1;
    cmp("lit_reset_empty", N'(empty), N'(1));
    cmp("lit_reset_full", N'(full), N'(0));

    // Basic ordered routing.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hB1);
    cmp("lit_if_v_A0", N'(if_valid), N'(1));
    cmp("lit_if_d_A0", if_data, 32'hA0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hC2);
    cmp("lit_mem_v_B1", N'(mem_valid), N'(1));
    cmp("lit_mem_d_B1", mem_data, 32'hB1);
    idle();
    cmp("lit_if_d_C2", if_data, 32'hC2);
    cmp("lit_empty_end", N'(empty), N'(1));

    // Fill, overflow, then push+pop while full.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, i[0], 1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    cmp("lit_full4", N'(full), N'(1));
    idle();
    cmp("lit_ovf_set", N'(ovf), N'(1));
    cmp("lit_still_full", N'(full), N'(1));
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h11);
    idle();
    cmp("lit_full_after_pp", N'(full), N'(1));
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, N'(32'h20 + i));
    idle();

    // Orphan response.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD);
    idle();
    cmp("lit_orphan", N'(orphan), N'(1));
    cmp("lit_orphan_no_if", N'(if_valid), N'(0));
    idle();
    cmp("lit_orphan_pulse", N'(orphan), N'(0));

    // Flush discards three outstanding responses.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, i[0], 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, N'(32'h70 + i));
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h55);
    idle();
    cmp("lit_flush_mem_v", N'(mem_valid), N'(1));
    cmp("lit_flush_mem_d", mem_data, 32'h55);

    // Wrap-around with alternating push/pop.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, i[0], 1'b0, 1'b0, '0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, N'(32'h100 + i));
    end
    idle();

    // Reset with requests outstanding.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    idle();
    cmp("lit_rst_empty", N'(empty), N'(1));
    cmp("lit_rst_ovf", N'(ovf), N'(0));
    cmp("lit_rst_if_d", if_data, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h99);
    idle();
    cmp("lit_rst_orphan", N'(orphan), N'(1));

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, fl, rf, rv, sel;
      r   = ($urandom_range(0, 299) != 0);
      fl  = ($urandom_range(0, 24) == 0);
      rf  = fl ? 1'b0 : ($urandom_range(0, 1) == 1);
      rv  = ($urandom_range(0, 99) < 45);
      sel = ($urandom_range(0, 1) == 1);
      drive(r, rf, sel, fl, rv, N'($urandom));
    end
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
